spi_master_tx: RTL and testbench

//  SPI mode-0 master that drives the ST7735R-style 4-wire display link (SCLK/CS/MOSI/DC), MSB first.

---
 rtl/spi_master_tx.sv | 185 ++++++++++++++++++
 tb/tb_spi_master_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 transmit master for a 4-wire display link (SCLK/CS/MOSI/DC), MSB first.
// Bytes arrive over valid/ready; CS stays low across bytes until one flagged last has gone out.
module spi_master_tx #(
  parameter int CLK_DIV      = 2,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2,
  parameter int CS_IDLE_CYC  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_dc,
  input  logic       i_tx_last,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_busy,
  output logic       o_spi_clk,
  output logic       o_spi_cs,
  output logic       o_spi_mosi,
  output logic       o_dc
);

  localparam int HCW  = $clog2(CLK_DIV + 1);
  localparam int WMAX = (CS_SETUP_CYC > CS_HOLD_CYC) ?
                        ((CS_SETUP_CYC > CS_IDLE_CYC) ? CS_SETUP_CYC : CS_IDLE_CYC) :
                        ((CS_HOLD_CYC > CS_IDLE_CYC) ? CS_HOLD_CYC : CS_IDLE_CYC);
  localparam int WCW  = $clog2(WMAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SHIFT  = 3'd2,
    NEXT   = 3'd3,
    HOLD   = 3'd4,
    CSIDLE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [HCW-1:0]   hcnt_q,  hcnt_d;
  logic [WCW-1:0]   wcnt_q,  wcnt_d;
  logic [2:0]       bcnt_q,  bcnt_d;
  logic             last_q,  last_d;
  logic             sclk_q,  sclk_d;
  logic             cs_q,    cs_d;
  logic             mosi_q,  mosi_d;
  logic             dc_q,    dc_d;
  logic             accept_s;

  assign o_tx_ready = !i_rst && ((state_q == IDLE) || (state_q == NEXT));
  assign o_busy     = !i_rst && (state_q != IDLE);
  assign accept_s   = i_tx_valid && o_tx_ready;

  assign o_spi_clk  = sclk_q;
  assign o_spi_cs   = cs_q;
  assign o_spi_mosi = mosi_q;
  assign o_dc       = dc_q;

  // Next-state and datapath: MOSI only moves on SCLK falling edges or on byte accept.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    hcnt_d  = hcnt_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    last_d  = last_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    dc_d    = dc_q;

    if (accept_s) begin
      shift_d = i_tx_data;
      mosi_d  = i_tx_data[7];
      last_d  = i_tx_last;
      dc_d    = i_tx_dc;
      hcnt_d  = '0;
      bcnt_d  = 3'd0;
      wcnt_d  = '0;
    end else begin
      shift_d = shift_q;
    end

    case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (accept_s) begin
          cs_d    = 1'b0;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (wcnt_q == WCW'(CS_SETUP_CYC - 1)) begin
          state_d = SHIFT;
          hcnt_d  = '0;
          bcnt_d  = 3'd0;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      SHIFT: begin
        if (hcnt_q == HCW'(CLK_DIV - 1)) begin
          hcnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bcnt_q == 3'd7) begin
              // Final bit stays on MOSI through NEXT/HOLD.
              state_d = last_q ? HOLD : NEXT;
              wcnt_d  = '0;
            end else begin
              bcnt_d  = bcnt_q + 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
              mosi_d  = shift_q[6];
            end
          end
        end else begin
          hcnt_d = hcnt_q + HCW'(1);
        end
      end
      NEXT: begin
        sclk_d = 1'b0;
        if (accept_s) begin
          state_d = SHIFT;
        end else begin
          state_d = NEXT;
        end
      end
      HOLD: begin
        if (wcnt_q == WCW'(CS_HOLD_CYC - 1)) begin
          cs_d    = 1'b1;
          state_d = CSIDLE;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      CSIDLE: begin
        if (wcnt_q == WCW'(CS_IDLE_CYC - 1)) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; a reset mid-frame drops the partial byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      shift_q <= 8'h00;
      hcnt_q  <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= 3'd0;
      last_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hcnt_q  <= hcnt_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: an SCLK-counting receiver model feeds a queue that is
// compared against bytes queued by the stimulus; frame timing is measured in clk cycles.
module tb_spi_master_tx;

  localparam int CD0 = 2;
  localparam int CD1 = 1;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int IDLEC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_dc = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       sel = 1'b0;

  logic rdy0, busy0, sclk0, cs0, mosi0, dc0;
  logic rdy1, busy1, sclk1, cs1, mosi1, dc1;
  logic rdy_m, busy_m, sclk_m, cs_m, mosi_m, dc_m;

  always #5 clk = ~clk;

  spi_master_tx #(.CLK_DIV(CD0), .CS_SETUP_CYC(SETUP), .CS_HOLD_CYC(HOLD), .CS_IDLE_CYC(IDLEC)) dut (
    .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data), .i_tx_dc(tx_dc), .i_tx_last(tx_last),
    .i_tx_valid(tx_valid & ~sel), .o_tx_ready(rdy0), .o_busy(busy0), .o_spi_clk(sclk0),
    .o_spi_cs(cs0), .o_spi_mosi(mosi0), .o_dc(dc0));

  spi_master_tx #(.CLK_DIV(CD1), .CS_SETUP_CYC(SETUP), .CS_HOLD_CYC(HOLD), .CS_IDLE_CYC(IDLEC)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data), .i_tx_dc(tx_dc), .i_tx_last(tx_last),
    .i_tx_valid(tx_valid & sel), .o_tx_ready(rdy1), .o_busy(busy1), .o_spi_clk(sclk1),
    .o_spi_cs(cs1), .o_spi_mosi(mosi1), .o_dc(dc1));

  assign rdy_m  = sel ? rdy1  : rdy0;
  assign busy_m = sel ? busy1 : busy0;
  assign sclk_m = sel ? sclk1 : sclk0;
  assign cs_m   = sel ? cs1   : cs0;
  assign mosi_m = sel ? mosi1 : mosi0;
  assign dc_m   = sel ? dc1   : dc0;

  // Receiver model and frame timing monitor, sampled on the falling clk edge.
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];
  int cyc = 0, frames = 0, frame_rises = 0, bad_clk = 0, dc_bad = 0;
  int t_csfall = 0, t_csrise = 0, t_first_rise = 0, t_last_fall = 0, t_busyfall = 0;
  int fr_rises = 0, fr_setup = 0, fr_hold = 0, fr_bytelen = 0, hi_time = 0, gap_time = 0;
  logic got_first = 1'b0;
  logic [2:0] rx_bits = 3'd0;
  logic [6:0] rx_sh = 7'd0;
  logic p_sclk = 1'b0, p_cs = 1'b1, p_dc = 1'b0, p_busy = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    p_sclk <= sclk_m; p_cs <= cs_m; p_dc <= dc_m; p_busy <= busy_m;
    if (!cs_m && p_cs) begin
      frames <= frames + 1;
      hi_time <= cyc - t_csrise;
      gap_time <= cyc - t_last_fall;
      frame_rises <= 0;
      rx_bits <= 3'd0;
      got_first <= 1'b0;
      t_csfall <= cyc;
    end
    if (cs_m && !p_cs) begin
      fr_rises <= frame_rises;
      fr_setup <= t_first_rise - t_csfall;
      fr_hold <= cyc - t_last_fall;
      fr_bytelen <= t_last_fall - t_first_rise;
      t_csrise <= cyc;
    end
    if (sclk_m && !p_sclk) begin
      if (cs_m) begin
        bad_clk <= bad_clk + 1;
      end else begin
        frame_rises <= frame_rises + 1;
        if (!got_first) begin
          t_first_rise <= cyc;
          got_first <= 1'b1;
        end
        rx_sh <= {rx_sh[5:0], mosi_m};
        rx_bits <= rx_bits + 3'd1;
        if (rx_bits == 3'd7) rx_q.push_back({dc_m, rx_sh, mosi_m});
      end
    end
    if (!sclk_m && p_sclk) t_last_fall <= cyc;
    if (!busy_m && p_busy) t_busyfall <= cyc;
    if ((dc_m != p_dc) && sclk_m) dc_bad <= dc_bad + 1;
  end

  int passed = 0, failed = 0, total = 0;
  logic [8:0] rxv[0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ge(input string tag, input int obs, input int lim);
    total++;
    assert (obs >= lim) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0d expected at least %0d", tag, obs, lim);
    end
  endtask

  task automatic chk_rx(input string tag, input int idx);
    logic [8:0] g;
    logic [8:0] e;
    g = 'x;
    e = 9'h000;
    if (rx_q.size() != 0) g = rx_q.pop_front();
    if (exp_q.size() != 0) e = exp_q.pop_front();
    rxv[idx] = g;
    chk(tag, 32'(g), 32'(e));
  endtask

  task automatic send(input logic [7:0] d, input logic dcv, input logic lastv, input bit push);
    int n;
    @(negedge clk);
    tx_data = d; tx_dc = dcv; tx_last = lastv; tx_valid = 1'b1;
    if (push) exp_q.push_back({dcv, d});
    n = 0;
    #1;
    while (!rdy_m && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (!rdy_m) chk("send_timeout", 32'd0, 32'd1);
    else @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!(cs_m && !busy_m) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (!(cs_m && !busy_m)) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_cs_rise(input string tag);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!(cs_m && busy_m) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (!(cs_m && busy_m)) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nfr;
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", 32'({cs_m, sclk_m, mosi_m, dc_m, busy_m, rdy_m}), 32'(6'b100000));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(rdy_m), 32'd1);

    // Single command byte 0x2A
    send(8'h2A, 1'b0, 1'b1, 1'b1);
    drop_valid();
    wait_end("t1_timeout");
    chk_rx("t1_byte", 0);
    chk("t1_rises", 32'(fr_rises), 32'd8);
    chk_ge("t1_setup", fr_setup, SETUP);
    chk("t1_bytelen", 32'(fr_bytelen), 32'(15 * CD0));
    chk("t1_hold", 32'(fr_hold), 32'(HOLD));
    chk("t1_busy_clear", 32'(t_busyfall - t_csrise), 32'(IDLEC));

    // RASET: one CS window, 5 bytes back to back
    nfr = frames;
    send(8'h2B, 1'b0, 1'b0, 1'b1);
    send(8'h00, 1'b1, 1'b0, 1'b1);
    send(8'h10, 1'b1, 1'b0, 1'b1);
    send(8'h00, 1'b1, 1'b0, 1'b1);
    send(8'h9F, 1'b1, 1'b1, 1'b1);
    drop_valid();
    wait_end("t2_timeout");
    for (int i = 0; i < 5; i++) chk_rx("t2_byte", i);
    chk("t2_raset", {rxv[1][7:0], rxv[2][7:0], rxv[3][7:0], rxv[4][7:0]}, 32'h0010_009F);
    chk("t2_rises", 32'(fr_rises), 32'd40);
    chk("t2_frames", 32'(frames - nfr), 32'd1);

    // RAMWR with one pixel
    send(8'h2C, 1'b0, 1'b0, 1'b1);
    send(8'hF8, 1'b1, 1'b0, 1'b1);
    send(8'h1F, 1'b1, 1'b1, 1'b1);
    drop_valid();
    wait_end("t3_timeout");
    for (int i = 0; i < 3; i++) chk_rx("t3_byte", i);
    chk("t3_pixel", 32'({rxv[1][7:0], rxv[2][7:0]}), 32'h0000_F81F);

    // Upstream stall in NEXT
    send(8'h81, 1'b1, 1'b0, 1'b1);
    drop_valid();
    n = 0;
    while (!(busy_m && rdy_m) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (50) @(negedge clk);
    #1;
    chk("t4_stall_lines", 32'({cs_m, sclk_m, mosi_m, rdy_m}), 32'(4'b0011));
    chk("t4_stall_rises", 32'(frame_rises), 32'd8);
    send(8'h3C, 1'b0, 1'b1, 1'b1);
    drop_valid();
    wait_end("t4_timeout");
    chk_rx("t4_byte0", 0);
    chk_rx("t4_byte1", 1);
    chk("t4_rises", 32'(fr_rises), 32'd16);

    // Reset after the 3rd rising edge
    send(8'h5A, 1'b0, 1'b1, 1'b0);
    drop_valid();
    n = 0;
    while (frame_rises < 3 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_reset_lines", 32'({cs_m, sclk_m, rdy_m}), 32'(3'b100));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_ready_release", 32'(rdy_m), 32'd1);
    send(8'hC3, 1'b1, 1'b1, 1'b1);
    drop_valid();
    wait_end("t5_timeout");
    chk_rx("t5_byte", 0);
    chk("t5_no_partial", 32'(rx_q.size()), 32'd0);

    // CS high time between back-to-back frames, then valid pulse in CSIDLE
    nfr = frames;
    send(8'h96, 1'b0, 1'b1, 1'b1);
    send(8'h69, 1'b1, 1'b1, 1'b1);
    drop_valid();
    wait_end("t6_timeout");
    chk_rx("t6_byte0", 0);
    chk_rx("t6_byte1", 1);
    chk("t6_frames", 32'(frames - nfr), 32'd2);
    chk_ge("t6_cs_high", hi_time, IDLEC);
    chk_ge("t6_fall_to_cs", gap_time, HOLD + IDLEC);

    send(8'h3C, 1'b0, 1'b1, 1'b1);
    drop_valid();
    wait_cs_rise("t6_rise_timeout");
    nfr = frames;
    @(negedge clk);
    tx_data = 8'hFF; tx_dc = 1'b1; tx_last = 1'b1; tx_valid = 1'b1;
    #1;
    chk("t6_csidle_ready", 32'({busy_m, rdy_m}), 32'(2'b10));
    @(negedge clk);
    tx_valid = 1'b0;
    wait_end("t6_end_timeout");
    repeat (8) @(negedge clk);
    #1;
    chk_rx("t6_byte2", 0);
    chk("t6_pulse_ignored", 32'({frames - nfr, 31'(rx_q.size())}), 32'd0);
    chk("t6_cs_idle", 32'(cs_m), 32'd1);

    // Same single-byte and back-to-back checks with CLK_DIV=1
    sel = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h2A, 1'b0, 1'b1, 1'b1);
    drop_valid();
    wait_end("d1_timeout");
    chk_rx("d1_byte", 0);
    chk("d1_rises", 32'(fr_rises), 32'd8);
    chk("d1_bytelen", 32'(fr_bytelen), 32'(15 * CD1));
    chk("d1_hold", 32'(fr_hold), 32'(HOLD));
    send(8'hA5, 1'b1, 1'b1, 1'b1);
    send(8'h5A, 1'b0, 1'b1, 1'b1);
    drop_valid();
    wait_end("d1b_timeout");
    chk_rx("d1_byte1", 1);
    chk_rx("d1_byte2", 2);
    chk_ge("d1_cs_high", hi_time, IDLEC);
    chk_ge("d1_fall_to_cs", gap_time, HOLD + IDLEC);

    chk("sclk_while_cs_high", 32'(bad_clk), 32'd0);
    chk("dc_change_sclk_high", 32'(dc_bad), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
